// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, IF/ID FIFO, jump redirect
// Optional macro IFU_ALIGN_CHECK_EN: misaligned redirect target halts fetch and raises if2cu_fault_o.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if2imem_req_o,
    output logic [31:0] if2imem_addr_o,
    input  logic        imem2if_ack_i,
    input  logic [31:0] imem2if_ins_i,
    input  logic        ex2if_jump_en_i,
    input  logic [31:0] ex2if_jump_addr_i,
    input  logic        cu2if_stall_i,
    output logic        if2ifid_valid_o,
    output logic [31:0] if2ifid_ins_o,
    output logic [31:0] if2ifid_addr_o,
    output logic        if2cu_fault_o
);
    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    logic [31:0]   pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          rst_q;
    logic          halted;
    logic          jump_take;
    logic [31:0]   jump_target;
    logic          push;
    logic          pop;
    logic [31:0]   ins_mem  [FIFO_DEPTH];
    logic [31:0]   addr_mem [FIFO_DEPTH];

`ifdef IFU_ALIGN_CHECK_EN
    // Once halted, only reset restarts fetch; later redirects are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (jump_take && (ex2if_jump_addr_i[1:0] != 2'b00)) begin
            halted <= 1'b1;
        end
    end
    assign jump_take     = ex2if_jump_en_i && !halted;
    assign jump_target   = ex2if_jump_addr_i;
    assign if2cu_fault_o = halted;
`else
    assign halted        = 1'b0;
    assign jump_take     = ex2if_jump_en_i;
    assign jump_target   = ex2if_jump_addr_i & 32'hFFFF_FFFC;
    assign if2cu_fault_o = 1'b0;
`endif

    assign if2imem_req_o   = !rst_q && !halted && (count < DEPTH_C) && !ex2if_jump_en_i;
    assign if2imem_addr_o  = pc;
    assign if2ifid_valid_o = (count != '0) && !ex2if_jump_en_i;
    assign if2ifid_ins_o   = (count != '0) ? ins_mem[rd_ptr]  : NOP;
    assign if2ifid_addr_o  = (count != '0) ? addr_mem[rd_ptr] : 32'h0;

    assign push = if2imem_req_o && imem2if_ack_i;
    assign pop  = if2ifid_valid_o && !cu2if_stall_i;

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr]  <= imem2if_ins_i;
            addr_mem[wr_ptr] <= pc;
        end
    end

    // Redirect outranks push/pop: any ack in the redirect cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (jump_take) begin
            pc     <= jump_target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
